// File: rtl/mem_arbiter.sv
// Two-requester round-robin front end for a single-ported word memory.
// Handles byte/half/word accesses with lane decode, alignment checks and a fixed 3-cycle response.
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            r0_valid_i,
    output logic            r0_ready_o,
    input  logic            r0_we_i,
    input  logic [1:0]      r0_size_i,
    input  logic [XLEN-1:0] r0_addr_i,
    input  logic [XLEN-1:0] r0_wdata_i,
    output logic            r0_rsp_valid_o,
    output logic [XLEN-1:0] r0_rsp_rdata_o,
    output logic            r0_rsp_err_o,

    input  logic            r1_valid_i,
    output logic            r1_ready_o,
    input  logic            r1_we_i,
    input  logic [1:0]      r1_size_i,
    input  logic [XLEN-1:0] r1_addr_i,
    input  logic [XLEN-1:0] r1_wdata_i,
    output logic            r1_rsp_valid_o,
    output logic [XLEN-1:0] r1_rsp_rdata_o,
    output logic            r1_rsp_err_o,

    output logic            mem_rd_o,
    output logic            mem_gwe_o,
    output logic [3:0]      mem_bw_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_data_o,
    input  logic [XLEN-1:0] mem_data_i
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Misaligned accesses and the reserved size never reach the memory.
    function automatic logic f_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] f_lanes(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] lanes;
        case (size)
            SZ_BYTE: lanes = 4'b0001 << off;
            SZ_HALF: lanes = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

    // Sub-word data is replicated so every enabled lane sees the right-justified value.
    function automatic logic [XLEN-1:0] f_wdata(input logic [1:0] size, input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] d;
        case (size)
            SZ_BYTE: d = {(XLEN/8){wdata[7:0]}};
            SZ_HALF: d = {(XLEN/16){wdata[15:0]}};
            SZ_WORD: d = wdata;
            default: d = {XLEN{1'b0}};
        endcase
        return d;
    endfunction

    function automatic logic [XLEN-1:0] f_extract(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      size,
                                                  input logic [1:0]      off);
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] d;
        shifted = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: d = {{(XLEN-8){1'b0}}, shifted[7:0]};
            SZ_HALF: d = {{(XLEN-16){1'b0}}, shifted[15:0]};
            SZ_WORD: d = shifted;
            default: d = {XLEN{1'b0}};
        endcase
        return d;
    endfunction

    state_t          r_state;
    logic            r_ptr;
    logic            r_cmd_idx;
    logic            r_cmd_we;
    logic            r_cmd_err;
    logic [1:0]      r_cmd_size;
    logic [XLEN-1:0] r_cmd_addr;
    logic [XLEN-1:0] r_cmd_wdata;
    logic            r_rsp_valid0;
    logic            r_rsp_valid1;
    logic            r_rsp_err0;
    logic            r_rsp_err1;
    logic [XLEN-1:0] r_rsp_rdata0;
    logic [XLEN-1:0] r_rsp_rdata1;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_accept;
    logic            w_sel_we;
    logic [1:0]      w_sel_size;
    logic [XLEN-1:0] w_sel_addr;
    logic [XLEN-1:0] w_sel_wdata;
    logic            w_sel_err;
    logic [XLEN-1:0] w_rsp_data;

    // Round-robin grant; r_ptr names the requester that wins a tie.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_ni && (r_state == ST_IDLE)) begin
            if (r0_valid_i && (!r1_valid_i || !r_ptr)) begin
                w_gnt0 = 1'b1;
            end else if (r1_valid_i) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign r0_ready_o  = w_gnt0;
    assign r1_ready_o  = w_gnt1;
    assign w_accept    = w_gnt0 | w_gnt1;
    assign w_sel_we    = w_gnt1 ? r1_we_i    : r0_we_i;
    assign w_sel_size  = w_gnt1 ? r1_size_i  : r0_size_i;
    assign w_sel_addr  = w_gnt1 ? r1_addr_i  : r0_addr_i;
    assign w_sel_wdata = w_gnt1 ? r1_wdata_i : r0_wdata_i;
    assign w_sel_err   = f_bad(w_sel_size, w_sel_addr[1:0]);
    assign w_rsp_data  = (r_cmd_we || r_cmd_err) ? {XLEN{1'b0}}
                                                 : f_extract(mem_data_i, r_cmd_size, r_cmd_addr[1:0]);

    // Memory port is decoded from the command register only while in ISSUE.
    always_comb begin
        mem_rd_o   = 1'b0;
        mem_gwe_o  = 1'b0;
        mem_bw_o   = 4'b0000;
        mem_addr_o = {XLEN{1'b0}};
        mem_data_o = {XLEN{1'b0}};
        if ((r_state == ST_ISSUE) && !r_cmd_err) begin
            mem_addr_o = r_cmd_addr;
            if (r_cmd_we) begin
                mem_data_o = f_wdata(r_cmd_size, r_cmd_wdata);
                if (r_cmd_size == SZ_WORD) begin
                    mem_gwe_o = 1'b1;
                end else begin
                    mem_bw_o = f_lanes(r_cmd_size, r_cmd_addr[1:0]);
                end
            end else begin
                mem_rd_o = 1'b1;
            end
        end else begin
            mem_addr_o = {XLEN{1'b0}};
        end
    end

    // Control FSM, command capture and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 1'b0;
            r_cmd_idx    <= 1'b0;
            r_cmd_we     <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_cmd_size   <= 2'b00;
            r_cmd_addr   <= {XLEN{1'b0}};
            r_cmd_wdata  <= {XLEN{1'b0}};
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_rsp_err0   <= 1'b0;
            r_rsp_err1   <= 1'b0;
            r_rsp_rdata0 <= {XLEN{1'b0}};
            r_rsp_rdata1 <= {XLEN{1'b0}};
        end else begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_rsp_err0   <= 1'b0;
            r_rsp_err1   <= 1'b0;
            r_rsp_rdata0 <= {XLEN{1'b0}};
            r_rsp_rdata1 <= {XLEN{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_ISSUE;
                        r_ptr       <= ~w_gnt1;
                        r_cmd_idx   <= w_gnt1;
                        r_cmd_we    <= w_sel_we;
                        r_cmd_err   <= w_sel_err;
                        r_cmd_size  <= w_sel_size;
                        r_cmd_addr  <= w_sel_addr;
                        r_cmd_wdata <= w_sel_wdata;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    if (r_cmd_idx) begin
                        r_rsp_valid1 <= 1'b1;
                        r_rsp_err1   <= r_cmd_err;
                        r_rsp_rdata1 <= w_rsp_data;
                    end else begin
                        r_rsp_valid0 <= 1'b1;
                        r_rsp_err0   <= r_cmd_err;
                        r_rsp_rdata0 <= w_rsp_data;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign r0_rsp_valid_o = r_rsp_valid0;
    assign r0_rsp_err_o   = r_rsp_err0;
    assign r0_rsp_rdata_o = r_rsp_rdata0;
    assign r1_rsp_valid_o = r_rsp_valid1;
    assign r1_rsp_err_o   = r_rsp_err1;
    assign r1_rsp_rdata_o = r_rsp_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a byte-level memory reference model.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        r0_valid_i, r0_ready_o, r0_we_i, r0_rsp_valid_o, r0_rsp_err_o;
    logic [1:0]  r0_size_i;
    logic [31:0] r0_addr_i, r0_wdata_i, r0_rsp_rdata_o;
    logic        r1_valid_i, r1_ready_o, r1_we_i, r1_rsp_valid_o, r1_rsp_err_o;
    logic [1:0]  r1_size_i;
    logic [31:0] r1_addr_i, r1_wdata_i, r1_rsp_rdata_o;
    logic        mem_rd_o, mem_gwe_o;
    logic [3:0]  mem_bw_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [31:0] mem_data_i = 32'h0;

    logic [31:0] tb_mem [16] = '{default: 32'h0};
    logic [7:0]  ref_b  [64];

    int n_vec  = 0;
    int n_fail = 0;
    int last_gnt;

    mem_arbiter #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .r0_valid_i(r0_valid_i), .r0_ready_o(r0_ready_o), .r0_we_i(r0_we_i),
        .r0_size_i(r0_size_i), .r0_addr_i(r0_addr_i), .r0_wdata_i(r0_wdata_i),
        .r0_rsp_valid_o(r0_rsp_valid_o), .r0_rsp_rdata_o(r0_rsp_rdata_o), .r0_rsp_err_o(r0_rsp_err_o),
        .r1_valid_i(r1_valid_i), .r1_ready_o(r1_ready_o), .r1_we_i(r1_we_i),
        .r1_size_i(r1_size_i), .r1_addr_i(r1_addr_i), .r1_wdata_i(r1_wdata_i),
        .r1_rsp_valid_o(r1_rsp_valid_o), .r1_rsp_rdata_o(r1_rsp_rdata_o), .r1_rsp_err_o(r1_rsp_err_o),
        .mem_rd_o(mem_rd_o), .mem_gwe_o(mem_gwe_o), .mem_bw_o(mem_bw_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous memory: read data appears after the edge that samples the strobe.
    always @(posedge clk_i) begin
        if (mem_rd_o) mem_data_i <= tb_mem[mem_addr_o[5:2]];
        if (mem_gwe_o) tb_mem[mem_addr_o[5:2]] <= mem_data_o;
        for (int k = 0; k < 4; k++) begin
            if (mem_bw_o[k]) begin
                tb_mem[mem_addr_o[5:2]][8*k +: 8] <= ($countones(mem_bw_o) == 2) ?
                    mem_data_o[8*(k%2) +: 8] : mem_data_o[7:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        return (a % (32'd1 << sz)) != 32'd0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < (1 << sz); i++) r |= 32'(ref_b[6'(a[5:0] + 6'(i))]) << (8 * i);
        return r;
    endfunction

    task automatic do_req(input int idx, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd_obs);
        logic        err_e;
        logic [31:0] mask, rexp;
        logic [3:0]  lanes_e;
        int          nb;
        err_e = ref_err(sz, a);
        nb    = (sz == 2'd3) ? 0 : (1 << sz);
        mask  = 32'((64'd1 << (8 * nb)) - 64'd1);
        @(negedge clk_i);
        if (idx == 0) begin
            r0_valid_i = 1'b1; r0_we_i = we; r0_size_i = sz; r0_addr_i = a; r0_wdata_i = wd;
        end else begin
            r1_valid_i = 1'b1; r1_we_i = we; r1_size_i = sz; r1_addr_i = a; r1_wdata_i = wd;
        end
        #1;
        chk("ready_own",   (idx == 0) ? r0_ready_o : r1_ready_o, 32'd1);
        chk("ready_other", (idx == 0) ? r1_ready_o : r0_ready_o, 32'd0);
        last_gnt = idx;
        @(negedge clk_i);
        r0_valid_i = 1'b0; r1_valid_i = 1'b0;
        r0_we_i = ~we; r1_we_i = ~we; r0_size_i = 2'($urandom); r1_size_i = 2'($urandom);
        r0_addr_i = $urandom; r1_addr_i = $urandom; r0_wdata_i = $urandom; r1_wdata_i = $urandom;
        #1;
        lanes_e = (we && !err_e && nb < 4) ? 4'(((1 << nb) - 1) << a[1:0]) : 4'b0000;
        chk("issue_rd",  mem_rd_o,  32'(!we && !err_e));
        chk("issue_gwe", mem_gwe_o, 32'(we && !err_e && sz == 2'd2));
        chk("issue_bw",  mem_bw_o,  lanes_e);
        if (!err_e) chk("issue_addr", mem_addr_o, a);
        if (we && !err_e) begin
            chk("issue_data", mem_data_o & mask, wd & mask);
            for (int i = 0; i < nb; i++) ref_b[6'(a[5:0] + 6'(i))] = wd[8*i +: 8];
        end
        @(negedge clk_i);
        #1;
        chk("resp_strobes", {mem_rd_o, mem_gwe_o, mem_bw_o}, 32'd0);
        chk("resp_early",   (idx == 0) ? r0_rsp_valid_o : r1_rsp_valid_o, 32'd0);
        @(negedge clk_i);
        #1;
        rexp   = (we || err_e) ? 32'h0 : ref_read(sz, a);
        rd_obs = (idx == 0) ? r0_rsp_rdata_o : r1_rsp_rdata_o;
        chk("rsp_valid", (idx == 0) ? r0_rsp_valid_o : r1_rsp_valid_o, 32'd1);
        chk("rsp_other", (idx == 0) ? r1_rsp_valid_o : r0_rsp_valid_o, 32'd0);
        chk("rsp_rdata", rd_obs, rexp);
        chk("rsp_err",   (idx == 0) ? r0_rsp_err_o : r1_rsp_err_o, 32'(err_e));
    endtask

    initial begin
        logic [31:0] rd;
        logic        due0 [24];
        logic        due1 [24];
        logic        e0, e1;
        int          next_free;
        logic [1:0]  sz;
        logic [31:0] off;

        for (int i = 0; i < 64; i++) ref_b[i] = 8'h00;
        for (int i = 0; i < 24; i++) begin due0[i] = 1'b0; due1[i] = 1'b0; end
        rst_ni = 1'b0; last_gnt = 1;
        r0_valid_i = 1'b1; r0_we_i = 1'b0; r0_size_i = 2'd0; r0_addr_i = 32'h0; r0_wdata_i = 32'h0;
        r1_valid_i = 1'b1; r1_we_i = 1'b0; r1_size_i = 2'd0; r1_addr_i = 32'h0; r1_wdata_i = 32'h0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_ready", {r0_ready_o, r1_ready_o}, 32'd0);
        chk("rst_mem",   {mem_rd_o, mem_gwe_o, mem_bw_o} | mem_addr_o | mem_data_o, 32'd0);
        chk("rst_rsp",   {r0_rsp_valid_o, r1_rsp_valid_o, r0_rsp_err_o, r1_rsp_err_o}
                         | r0_rsp_rdata_o | r1_rsp_rdata_o, 32'd0);
        r0_valid_i = 1'b0; r1_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        do_req(0, 1'b1, 2'd2, 32'h4000_0000, 32'hDEAD_BEEF, rd);
        do_req(0, 1'b0, 2'd2, 32'h4000_0000, 32'h0, rd);
        chk("word_read", rd, 32'hDEAD_BEEF);
        do_req(0, 1'b0, 2'd1, 32'h4000_0002, 32'h0, rd);
        chk("half_read", rd, 32'h0000_DEAD);
        do_req(0, 1'b1, 2'd0, 32'h4000_0003, 32'h0000_00AA, rd);
        do_req(0, 1'b0, 2'd2, 32'h4000_0000, 32'h0, rd);
        chk("byte_merge", rd, 32'hAAAD_BEEF);
        do_req(1, 1'b1, 2'd1, 32'h4000_0002, 32'h0000_1234, rd);
        do_req(0, 1'b0, 2'd2, 32'h4000_0001, 32'h0, rd);
        do_req(1, 1'b0, 2'd3, 32'h4000_0000, 32'h0, rd);

        do_req(0, 1'b1, 2'd2, 32'h4000_0010, 32'h1111_2222, rd);
        do_req(1, 1'b1, 2'd2, 32'h4000_0014, 32'h3333_4444, rd);
        r0_we_i = 1'b0; r0_size_i = 2'd2; r0_addr_i = 32'h4000_0010;
        r1_we_i = 1'b0; r1_size_i = 2'd2; r1_addr_i = 32'h4000_0014;
        next_free = 0;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk_i);
            r0_valid_i = (t <= 12); r1_valid_i = (t <= 12);
            #1;
            e0 = 1'b0; e1 = 1'b0;
            if (t <= 12 && t >= next_free) begin
                if (last_gnt == 0) begin e1 = 1'b1; due1[t+3] = 1'b1; last_gnt = 1; end
                else begin e0 = 1'b1; due0[t+3] = 1'b1; last_gnt = 0; end
                next_free = t + 3;
            end
            chk("rr_ready0", r0_ready_o, 32'(e0));
            chk("rr_ready1", r1_ready_o, 32'(e1));
            chk("rr_rsp0",   r0_rsp_valid_o, 32'(due0[t]));
            chk("rr_rsp1",   r1_rsp_valid_o, 32'(due1[t]));
            if (due0[t]) chk("rr_rdata0", r0_rsp_rdata_o, ref_read(2'd2, 32'h4000_0010));
            if (due1[t]) chk("rr_rdata1", r1_rsp_rdata_o, ref_read(2'd2, 32'h4000_0014));
        end

        for (int n = 0; n < 40; n++) begin
            sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            off = 32'($urandom_range(0, 3));
            if (sz != 2'd3 && $urandom_range(0, 2) != 0) off = off & ~((32'd1 << sz) - 32'd1);
            do_req($urandom_range(0, 1), 1'($urandom_range(0, 1)), sz,
                   32'h4000_0000 + 32'($urandom_range(0, 7)) * 32'd4 + off, $urandom, rd);
        end

        @(negedge clk_i);
        r1_valid_i = 1'b1; r1_we_i = 1'b1; r1_size_i = 2'd2;
        r1_addr_i = 32'h4000_0030; r1_wdata_i = 32'hCAFE_F00D;
        #1;
        chk("ab_ready1", r1_ready_o, 32'd1);
        @(negedge clk_i);
        #1;
        chk("ab_issue", mem_gwe_o, 32'd1);
        r0_valid_i = 1'b1;
        rst_ni = 1'b0;
        #1;
        chk("ab_ready", {r0_ready_o, r1_ready_o}, 32'd0);
        chk("ab_mem",   {mem_rd_o, mem_gwe_o, mem_bw_o} | mem_addr_o | mem_data_o, 32'd0);
        chk("ab_rsp",   {r0_rsp_valid_o, r1_rsp_valid_o, r0_rsp_err_o, r1_rsp_err_o}, 32'd0);
        r0_valid_i = 1'b0; r1_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1; last_gnt = 1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk_i);
            #1;
            chk("ab_quiet", {r0_rsp_valid_o, r1_rsp_valid_o, mem_rd_o, mem_gwe_o, mem_bw_o}, 32'd0);
        end
        @(negedge clk_i);
        r0_valid_i = 1'b1; r0_we_i = 1'b0; r0_size_i = 2'd2; r0_addr_i = 32'h4000_0030;
        r1_valid_i = 1'b1; r1_we_i = 1'b0; r1_size_i = 2'd2; r1_addr_i = 32'h4000_0030;
        #1;
        chk("post_rst_r0", r0_ready_o, 32'd1);
        chk("post_rst_r1", r1_ready_o, 32'd0);
        @(negedge clk_i);
        r0_valid_i = 1'b0; r1_valid_i = 1'b0;
        #1;
        chk("post_rst_rd", mem_rd_o, 32'd1);
        repeat (2) @(negedge clk_i);
        #1;
        chk("post_rst_rsp",   r0_rsp_valid_o, 32'd1);
        chk("post_rst_rdata", r0_rsp_rdata_o, ref_read(2'd2, 32'h4000_0030));
        chk("post_rst_r1rsp", r1_rsp_valid_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: XLEN, default 32, word and address width; byte address width fixed at 2 (4 bytes per word).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 r0_valid_i  input  1  requester 0 request valid.
REQ-005 r0_ready_o  output  1  requester 0 request accepted this cycle when high with r0_valid_i.
REQ-006 r0_we_i  input  1  1 = write, 0 = read.
REQ-007 r0_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 r0_addr_i  input  XLEN  byte address.
REQ-009 r0_wdata_i  input  XLEN  write data, right-justified (byte in [7:0], half in [15:0]).
REQ-010 r0_rsp_valid_o  output  1  one-cycle response pulse.
REQ-011 r0_rsp_rdata_o  output  XLEN  read data, zero-extended and right-justified; 0 for writes and errors.
REQ-012 r0_rsp_err_o  output  1  misaligned or reserved-size request; qualified by r0_rsp_valid_o.
REQ-013 r1_valid_i, r1_ready_o, r1_we_i, r1_size_i, r1_addr_i, r1_wdata_i, r1_rsp_valid_o, r1_rsp_rdata_o, r1_rsp_err_o: same directions, widths and meanings as the r0_ ports, for requester 1.
REQ-014 mem_rd_o  output  1  memory read strobe.
REQ-015 mem_gwe_o  output  1  memory full-word write enable.
REQ-016 mem_bw_o  output  4  memory byte write enables, bit k = byte lane k.
REQ-017 mem_addr_o  output  XLEN  memory byte address.
REQ-018 mem_data_o  output  XLEN  memory write data.
REQ-019 mem_data_i  input  XLEN  memory read word, valid from the edge after the read strobe is sampled.

Function
REQ-020 FSM states IDLE, ISSUE, RESP; IDLE -> ISSUE on accept; ISSUE -> RESP unconditionally; RESP -> IDLE unconditionally.
REQ-021 Ready asserted only in IDLE, at most one ready high per cycle, combinational from valids and the round-robin pointer.
REQ-022 Round-robin: single request granted; both valid -> grant the requester not granted last; pointer updates on every accept.
REQ-023 Accept latches grant index, we, size, addr, wdata into a command register; later changes on requester inputs are ignored.
REQ-024 ISSUE: mem_* driven from the command register for exactly one cycle; all mem strobes 0 in every other state.
REQ-025 Word (size 10, addr[1:0]=00): read -> mem_rd_o=1; write -> mem_gwe_o=1, mem_data_o=wdata.
REQ-026 Half (size 01, addr[0]=0): write offset 0 -> mem_bw_o=0011, offset 2 -> 1100; mem_data_o[15:0]=wdata[15:0]; mem_gwe_o=0.
REQ-027 Byte (size 00): write offset k -> mem_bw_o bit k only; mem_data_o[7:0]=wdata[7:0].
REQ-028 Sub-word reads drive mem_rd_o=1 with the unmodified byte address.
REQ-029 mem_addr_o = command address for every issued access.
REQ-030 Misaligned (word addr[1:0]!=0, half addr[0]=1) or size 11: no strobe in ISSUE; response carries err=1, rdata=0.
REQ-031 RESP: registered capture of mem_data_i shifted right by 8*addr[1:0], masked to access size; rsp_valid of granted requester high for the cycle after RESP.
REQ-032 Latency: accept edge E0, memory sampled at E1, rsp_valid high in the cycle following E2; max one outstanding request; next accept at earliest in the cycle rsp_valid is high.
REQ-033 Writes respond with rsp_valid pulse, rdata=0, err=0.

Reset
REQ-034 rst_ni low: state IDLE, pointer favours requester 0, command register cleared, all outputs 0, immediately and independent of clk_i.
REQ-035 Reset mid-operation aborts the in-flight request; no response pulse is generated for it.

Verification
REQ-036 Word write r0 addr 0x40000000 data 0xDEADBEEF, then word read -> mem_gwe_o one cycle; read response rdata 0xDEADBEEF, err 0, 3 cycles after accept.
REQ-037 r0 and r1 valid every cycle -> grants alternate r0, r1, r0, r1; no cycle with both ready high.
REQ-038 Byte write 0xAA at 0x40000003 -> mem_bw_o=1000, mem_data_o[7:0]=0xAA; word read returns 0xAAADBEEF.
REQ-039 Half read at 0x40000002 after REQ-036 -> rdata 0x0000DEAD; half write at 0x40000002 -> mem_bw_o=1100.
REQ-040 Word read at 0x40000001 and size 11 -> no memory strobe, rsp_valid with err 1, rdata 0.
REQ-041 rst_ni low during ISSUE -> all outputs 0 at once, no rsp_valid afterwards, first request after release granted to r0.
